// File: rtl/mult_seq_n.sv
// Sequential shift-add multiplier: WIDTH x WIDTH -> 2*WIDTH, signed or unsigned per operation.
// Define MULT_SEQ_ZERO_SKIP_EN to finish a zero-operand multiply in one cycle.
module mult_seq_n #(
   parameter int WIDTH = 8
) (
   input  logic                 CLK,
   input  logic                 Rst,
   input  logic                 St,
   input  logic                 Sgn,
   input  logic [WIDTH-1:0]     Mplier,
   input  logic [WIDTH-1:0]     Mcand,
   output logic [2*WIDTH-1:0]   Product,
   output logic                 Done,
   output logic                 Busy
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t               state_q, state_d;
   logic [WIDTH:0]       a_q, a_d;
   logic [WIDTH-1:0]     b_q, b_d;
   logic [WIDTH-1:0]     mcand_q, mcand_d;
   logic                 sgn_q, sgn_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [2*WIDTH-1:0]   prod_q, prod_d;

   // One guard bit beyond A's WIDTH+1 bits keeps the sum exact before the shift.
   logic [WIDTH+1:0]     a_ext, m_ext, addend, sum;
   logic                 last_step;

   always_comb begin
      last_step = (cnt_q == CW'(WIDTH - 1));
      a_ext     = sgn_q ? {a_q[WIDTH], a_q} : {1'b0, a_q};
      m_ext     = sgn_q ? {{2{mcand_q[WIDTH-1]}}, mcand_q} : {2'b00, mcand_q};
      if (!b_q[0])
         addend = '0;
      else if (sgn_q && last_step)
         addend = ~m_ext + {{(WIDTH+1){1'b0}}, 1'b1};
      else
         addend = m_ext;
      sum = a_ext + addend;
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      mcand_d = mcand_q;
      sgn_d   = sgn_q;
      cnt_d   = cnt_q;
      prod_d  = prod_q;
      case (state_q)
         IDLE: begin
            if (St) begin
               a_d     = '0;
               b_d     = Mplier;
               mcand_d = Mcand;
               sgn_d   = Sgn;
               cnt_d   = '0;
               state_d = RUN;
`ifdef MULT_SEQ_ZERO_SKIP_EN
               if (Mplier == '0 || Mcand == '0) begin
                  prod_d  = '0;
                  state_d = DONE;
               end
`endif
            end
         end
         RUN: begin
            a_d   = sum[WIDTH+1:1];
            b_d   = {sum[0], b_q[WIDTH-1:1]};
            cnt_d = cnt_q + CW'(1);
            if (last_step) begin
               prod_d  = {sum[WIDTH:1], sum[0], b_q[WIDTH-1:1]};
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (Rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         mcand_q <= '0;
         sgn_q   <= 1'b0;
         cnt_q   <= '0;
         prod_q  <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         mcand_q <= mcand_d;
         sgn_q   <= sgn_d;
         cnt_q   <= cnt_d;
         prod_q  <= prod_d;
      end
   end

   assign Product = prod_q;
   assign Done    = (state_q == DONE);
   assign Busy    = (state_q != IDLE);

endmodule

// File: tb/tb_mult_seq_n.sv
// Directed bench for mult_seq_n at WIDTH=8: products, latency, Busy/Done timing,
// back-to-back starts, mid-operation reset and the optional zero-skip path.
module tb_mult_seq_n;

   logic        CLK = 1'b0;
   logic        Rst = 1'b1;
   logic        St = 1'b0;
   logic        Sgn = 1'b0;
   logic [7:0]  Mplier = '0;
   logic [7:0]  Mcand = '0;
   logic [15:0] Product;
   logic        Done;
   logic        Busy;

   int n_checks = 0;
   int n_errors = 0;

   mult_seq_n #(.WIDTH(8)) dut (
      .CLK(CLK), .Rst(Rst), .St(St), .Sgn(Sgn),
      .Mplier(Mplier), .Mcand(Mcand),
      .Product(Product), .Done(Done), .Busy(Busy)
   );

   always #5 CLK = ~CLK;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Start one operation from IDLE, scramble the inputs during RUN, then check
   // latency, Busy coverage, product and the return to IDLE.
   task automatic do_op(input logic [7:0] mp, input logic [7:0] mc, input logic s,
                        input logic [15:0] exp_p, input int exp_lat, input string tag);
      int lat, busy_n;
      bit disturbed;
      logic [15:0] prev;
      prev = Product;
      @(negedge CLK);
      Mplier = mp; Mcand = mc; Sgn = s; St = 1'b1;
      @(posedge CLK); #1;
      St = 1'b0; Mplier = ~mp; Mcand = ~mc; Sgn = ~s;
      lat = 0; busy_n = 0; disturbed = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         if (Busy) busy_n++;
         if (Done) begin
            lat = i;
            break;
         end
         if (Product !== prev) disturbed = 1'b1;
         @(posedge CLK); #1;
      end
      $display("op %s: mplier=%02h mcand=%02h sgn=%0d product=%04h latency=%0d",
               tag, mp, mc, s, Product, lat);
      check_val({tag, "_latency"}, lat, exp_lat);
      check_val({tag, "_product"}, Product, exp_p);
      check_val({tag, "_busy_cycles"}, busy_n, exp_lat);
      check_val({tag, "_held_in_run"}, disturbed, 0);
      @(posedge CLK); #1;
      check_val({tag, "_idle_after"}, {Done, Busy}, 2'b00);
      check_val({tag, "_product_hold"}, Product, exp_p);
   endtask

   int zl;
   int done_cyc[$];
   int n_done;

   initial begin
`ifdef MULT_SEQ_ZERO_SKIP_EN
      zl = 1;
`else
      zl = 9;
`endif
      repeat (2) @(posedge CLK);
      #1;
      check_val("reset_state", {Product, Done, Busy}, 18'h0);
      Rst = 1'b0;

      do_op(8'h80, 8'h80, 1'b1, 16'h4000, 9, "s_neg_x_neg");
      do_op(8'h05, 8'hFD, 1'b1, 16'hFFF1, 9, "s_5_x_m3");
      do_op(8'hFD, 8'h05, 1'b1, 16'hFFF1, 9, "s_m3_x_5");
      do_op(8'hFF, 8'hFF, 1'b0, 16'hFE01, 9, "u_ff_x_ff");
      do_op(8'hFF, 8'hFF, 1'b1, 16'h0001, 9, "s_m1_x_m1");
      do_op(8'h7F, 8'h80, 1'b1, 16'hC080, 9, "s_7f_x_80");
      do_op(8'h0F, 8'h10, 1'b0, 16'h00F0, 9, "u_0f_x_10");
      do_op(8'h80, 8'h80, 1'b0, 16'h4000, 9, "u_80_x_80");
      do_op(8'h00, 8'h55, 1'b0, 16'h0000, zl, "zero_mplier");
      do_op(8'h55, 8'h00, 1'b1, 16'h0000, zl, "zero_mcand");

      // St held high: a new operation every WIDTH+2 cycles, junk operands during RUN.
      @(negedge CLK);
      Mplier = 8'h03; Mcand = 8'h04; Sgn = 1'b0; St = 1'b1;
      n_done = 0;
      for (int c = 0; c < 45; c++) begin
         @(posedge CLK); #1;
         if (Done) begin
            done_cyc.push_back(c);
            check_val("b2b_product", Product, 16'h000C);
            Mplier = 8'h03; Mcand = 8'h04; Sgn = 1'b0;
         end else if (Busy) begin
            Mplier = 8'hA5; Mcand = 8'h5A; Sgn = 1'b1;
         end
      end
      St = 1'b0;
      n_done = done_cyc.size();
      $display("b2b: done pulses=%0d", n_done);
      check_val("b2b_pulse_count", n_done, 4);
      if (n_done > 0) check_val("b2b_first_done", done_cyc[0], 8);
      for (int i = 1; i < n_done; i++)
         check_val("b2b_period", done_cyc[i] - done_cyc[i-1], 10);
      repeat (12) @(posedge CLK);
      #1;
      check_val("b2b_idle", {Done, Busy}, 2'b00);

      // Reset four edges after acceptance aborts the operation.
      @(negedge CLK);
      Mplier = 8'h7F; Mcand = 8'h7F; Sgn = 1'b0; St = 1'b1;
      @(posedge CLK); #1;
      St = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      Rst = 1'b1;
      @(posedge CLK); #1;
      Rst = 1'b0;
      $display("abort: product=%04h busy=%0d done=%0d", Product, Busy, Done);
      check_val("abort_state", {Product, Done, Busy}, 18'h0);
      n_done = 0;
      for (int c = 0; c < 12; c++) begin
         @(posedge CLK); #1;
         if (Done || Busy) n_done++;
      end
      check_val("abort_no_done", n_done, 0);
      do_op(8'h7F, 8'h7F, 1'b1, 16'h3F01, 9, "after_abort");

      // Reset and start on the same edge: start is discarded.
      @(negedge CLK);
      Mplier = 8'h12; Mcand = 8'h34; St = 1'b1; Rst = 1'b1;
      @(posedge CLK); #1;
      St = 1'b0; Rst = 1'b0;
      $display("rst_vs_st: busy=%0d product=%04h", Busy, Product);
      check_val("rst_beats_st", {Product, Done, Busy}, 18'h0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/mult_seq_n.md
Name: mult_seq_n

Overview:
- Parametrised sequential shift-add multiplier.
- Generalises the fixed 4x4 two's-complement multiplier to WIDTH-bit operands.
- Produces a full 2*WIDTH-bit product, with a per-operation signed/unsigned mode and a Busy flag.
- Sits on a datapath as a multi-cycle arithmetic unit driven by a start/done handshake.

Parameters:
- WIDTH, 8, operand width in bits; legal range 2..32. Iteration counter width is derived internally as clog2(WIDTH+1).

Ports:
- CLK  input  1  rising-edge clock
- Rst  input  1  synchronous, active-high reset
- St  input  1  start request; sampled only in IDLE
- Sgn  input  1  1 = signed two's-complement operands, 0 = unsigned; sampled with St
- Mplier  input  WIDTH  multiplier operand
- Mcand  input  WIDTH  multiplicand operand
- Product  output  2*WIDTH  registered result
- Done  output  1  one-cycle pulse; Product valid
- Busy  output  1  high whenever state != IDLE

Behaviour:
- Single clock CLK. Rst is synchronous and active-high; it overrides all other inputs.
- Reset values: state=IDLE, Product=0, Done=0, Busy=0. Internal A, B, counter and mode are cleared.
- States: IDLE, RUN, DONE.
  - IDLE: if St=1 at an edge, latch Mcand, Sgn and B<=Mplier, set A<=0 and count<=0, go to RUN. Otherwise stay.
  - RUN: one multiplier bit per cycle, LSB first. M=B[0].
    - Steps 0..WIDTH-2: if M=1, A+Mcand then shift; else shift only.
    - Step WIDTH-1 with Sgn=1 and M=1: A-Mcand (two's-complement add of ~Mcand+1), then shift.
    - Step WIDTH-1 otherwise: same as earlier steps.
    - Shift right of {A,B} by 1.
      - Signed mode: new MSB of A is the sign of the (WIDTH+1)-bit sum.
      - Unsigned mode: new MSB of A is the carry out.
    - A is WIDTH+1 bits internally, so no overflow is possible.
    - After WIDTH RUN cycles go to DONE and load Product<={A[WIDTH-1:0],B}.
  - DONE: Done=1 for exactly this cycle; next state is always IDLE.
- Latency: St accepted at edge k; Done high in cycle k+WIDTH+1; Busy high cycles k+1..k+WIDTH+1. Earliest next acceptance is edge k+WIDTH+2, i.e. St held high yields back-to-back operations with one IDLE cycle between.
- Product holds its value from DONE until the next operation reaches DONE. It is not disturbed during RUN.
- St in RUN or DONE is ignored. Mplier, Mcand and Sgn changing during RUN have no effect.
- Corner cases that must be exact:
  - Signed most-negative x most-negative gives the positive 2*WIDTH-bit result.
  - Unsigned all-ones x all-ones gives the full result.
- Rst mid-operation: the next state is IDLE and Product is cleared to 0. No Done pulse is emitted for the aborted operation.
- Rst and St high on the same edge: reset wins and the operation is not accepted.

Optional Feature:
- Macro: MULT_SEQ_ZERO_SKIP_EN
- Defined: in IDLE, if St=1 and (Mplier==0 or Mcand==0), go directly to DONE with Product<=0. Done then pulses at k+1, and Busy is high only in cycle k+1.
- Undefined: zero operands take the normal WIDTH-cycle path, and latency is always WIDTH+1.

Test Plan (WIDTH=8):
- Sgn=1, Mplier=0x80, Mcand=0x80, St pulse -> Done at k+9, Product=0x4000, Busy high k+1..k+9.
- Sgn=1, Mplier=0x05, Mcand=0xFD (-3) -> Product=0xFFF1 (-15). Swapping the operands gives the same result.
- Sgn=0, Mplier=0xFF, Mcand=0xFF -> Product=0xFE01. The same operands with Sgn=1 -> Product=0x0001.
- St held high continuously with Mplier=0x03, Mcand=0x04, Sgn=0 -> Done pulses every 10 cycles, Product=0x000C. St during RUN and DONE causes no restart; changing the operands mid-RUN leaves the result unchanged.
- Start 0x7F x 0x7F, assert Rst at k+4 -> cycle after: Busy=0, Product=0, state IDLE, no Done. A new St then completes normally with Product=0x3F01.
- MULT_SEQ_ZERO_SKIP_EN defined: Mplier=0x00, Mcand=0x55 -> Done at k+1, Product=0. With the macro undefined -> Done at k+9, Product=0.
